// File: rtl/dmem_resp_pkg.sv
// Shared MMIO address map, STATUS bit layout and address decode for dmem_responder.
package dmem_resp_pkg;

  localparam logic [11:0] ADDR_CYCLE  = 12'hF00;
  localparam logic [11:0] ADDR_TCMP   = 12'hF01;
  localparam logic [11:0] ADDR_STATUS = 12'hF02;
  localparam logic [11:0] ADDR_TXDATA = 12'hF03;

  localparam int unsigned ST_IRQ    = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_EMPTY  = 2;
  localparam int unsigned ST_OVF    = 3;
  localparam int unsigned ST_CNT_LO = 4;
  localparam int unsigned ST_CNT_HI = 6;

  typedef enum logic [2:0] {
    RG_RAM,
    RG_CYCLE,
    RG_TCMP,
    RG_STATUS,
    RG_TXDATA,
    RG_NONE
  } region_e;

  function automatic region_e decode(input logic [11:0] a, input int unsigned ram_words);
    if ({20'b0, a} < ram_words) return RG_RAM;
    case (a)
      ADDR_CYCLE:  return RG_CYCLE;
      ADDR_TCMP:   return RG_TCMP;
      ADDR_STATUS: return RG_STATUS;
      ADDR_TXDATA: return RG_TXDATA;
      default:     return RG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// Synchronous transmit FIFO (power-of-two depth, no fall-through); head reads 0 when empty.
module dmem_resp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM region plus CYCLE/TCMP/STATUS/TXDATA MMIO window.
// Timer compare and irq exist only when DMEM_RESP_TIMER_EN is defined.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  region_e        region;
  logic [AW-1:0]  ram_idx;
  logic [31:0]    mem [RAM_WORDS];
  logic [31:0]    cycle_cnt;
  logic [31:0]    tcmp_rd;
  logic           irq_pend;
  logic           overflow;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           wr_status;
  logic           wr_tx;
  logic           pop;
  logic           ovf_set;
  logic [31:0]    status;
  logic [31:0]    rd_mux;

  assign region    = decode(address, RAM_WORDS);
  assign ram_idx   = address[AW-1:0];
  assign wr_status = wren && (region == RG_STATUS);
  assign wr_tx     = wren && (region == RG_TXDATA);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign ovf_set   = wr_tx && fifo_full && !pop;

  dmem_resp_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (wr_tx),
    .pop   (pop),
    .wdata (data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (wren && (region == RG_RAM)) mem[ram_idx] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      overflow  <= ovf_set | (overflow & ~(wr_status & data[ST_OVF]));
    end
  end

`ifdef DMEM_RESP_TIMER_EN
  logic [31:0] tcmp;

  // A compare hit on the same edge as a W1C clear keeps irq_pend set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcmp     <= '1;
      irq_pend <= 1'b0;
    end else begin
      if (wren && (region == RG_TCMP)) tcmp <= data;
      irq_pend <= (cycle_cnt == tcmp) | (irq_pend & ~(wr_status & data[ST_IRQ]));
    end
  end

  assign tcmp_rd = tcmp;
`else
  assign tcmp_rd  = '0;
  assign irq_pend = 1'b0;
`endif

  assign irq = irq_pend;

  always_comb begin
    status                      = '0;
    status[ST_IRQ]              = irq_pend;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_OVF]              = overflow;
    status[ST_CNT_HI:ST_CNT_LO] = 3'(fifo_count);
  end

  always_comb begin
    rd_mux = '0;
    case (region)
      RG_RAM:    rd_mux = mem[ram_idx];
      RG_CYCLE:  rd_mux = cycle_cnt;
      RG_TCMP:   rd_mux = tcmp_rd;
      RG_STATUS: rd_mux = status;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= rd_mux;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a transaction-level model (queue FIFO, array RAM).
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] address = 12'h800;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] q;
  logic [31:0] out_data;
  logic        out_valid;
  logic        irq;

  dmem_responder #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .q         (q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  always #5 clock = ~clock;

`ifdef DMEM_RESP_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ram_m [1024];
  bit          ram_known [1024];
  logic [31:0] m_cycle;
  logic [31:0] m_tcmp;
  bit          m_irq;
  bit          m_ovf;
  logic [31:0] fifo_m [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cycle = 0;
    m_tcmp  = 32'hFFFF_FFFF;
    m_irq   = 0;
    m_ovf   = 0;
    fifo_m.delete();
  endtask

  function automatic logic [31:0] model_status();
    int unsigned n = fifo_m.size();
    return 32'(TIMER && m_irq) + ((n == 4) ? 32'd2 : 32'd0) + ((n == 0) ? 32'd4 : 32'd0)
         + (m_ovf ? 32'd8 : 32'd0) + 32'(n * 16);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a < 12'd1024) return ram_m[a[9:0]];
    case (a)
      12'hF00: return m_cycle;
      12'hF01: return TIMER ? m_tcmp : 32'd0;
      12'hF02: return model_status();
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive inputs, advance the model across the edge, check outputs 1 time unit later.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic we, input logic rdy);
    logic [31:0] exp_q;
    bit          q_known;
    bit          popped;
    bit          ovf_set;
    bit          irq_set;
    address   = a;
    data      = d;
    wren      = we;
    out_ready = rdy;
    @(posedge clock);
    exp_q   = model_read(a);
    q_known = (a >= 12'd1024) || ram_known[a[9:0]];
    popped  = rdy && (fifo_m.size() > 0);
    irq_set = (m_cycle == m_tcmp);
    ovf_set = 0;
    if (popped) void'(fifo_m.pop_front());
    if (we && a == 12'hF03) begin
      if (fifo_m.size() < 4) fifo_m.push_back(d);
      else ovf_set = 1;
    end
    m_irq = irq_set || (m_irq && !(we && a == 12'hF02 && d[0]));
    m_ovf = ovf_set || (m_ovf && !(we && a == 12'hF02 && d[3]));
    if (we && a == 12'hF01) m_tcmp = d;
    if (we && a < 12'd1024) begin
      ram_m[a[9:0]]     = d;
      ram_known[a[9:0]] = 1;
    end
    m_cycle = m_cycle + 1;
    #1;
    if (q_known) chk("q", q, exp_q);
    chk("out_valid", 32'(out_valid), 32'(fifo_m.size() > 0));
    chk("out_data", out_data, (fifo_m.size() > 0) ? fifo_m[0] : 32'd0);
    chk("irq", 32'(irq), 32'(TIMER && m_irq));
  endtask

  task automatic idle(input logic rdy);
    step(12'h800, 32'd0, 1'b0, rdy);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) ram_known[i] = 0;
    model_reset();

    #12;
    chk("reset_q", q, 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    @(negedge clock) reset = 1'b1;

    for (int i = 1; i <= 9; i++) idle(1'b0);
    step(12'hF00, 32'd0, 1'b0, 1'b0);
    chk("cycle_edge10", q, 32'd9);

    step(12'h005, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(12'h005, 32'd0, 1'b0, 1'b0);
    chk("ram_read", q, 32'hDEAD_BEEF);
    step(12'h005, 32'h1234_5678, 1'b1, 1'b0);
    chk("ram_rdw_old", q, 32'hDEAD_BEEF);
    step(12'h005, 32'd0, 1'b0, 1'b0);
    chk("ram_new", q, 32'h1234_5678);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: a = 12'($urandom_range(0, 15));
        1: a = 12'($urandom_range(0, 1023));
        2: a = 12'($urandom_range(12'h400, 12'hEFF));
        default: a = 12'($urandom_range(12'hF04, 12'hFFF));
      endcase
      step(a, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    step(12'hF00, 32'h5555_5555, 1'b1, 1'b0);
    step(12'hF00, 32'd0, 1'b0, 1'b0);

`ifdef DMEM_RESP_TIMER_EN
    v = m_cycle + 32'd20;
    step(12'hF01, v, 1'b1, 1'b0);
    step(12'hF01, 32'd0, 1'b0, 1'b0);
    chk("tcmp_read", q, v);
    for (int i = 0; i < 30; i++) idle(1'b0);
    chk("irq_after_match", 32'(irq), 32'd1);
    step(12'hF02, 32'h1, 1'b1, 1'b0);
    chk("irq_cleared", 32'(irq), 32'd0);
    step(12'hF01, m_cycle + 32'd4, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_cycle != m_tcmp; i++) idle(1'b0);
    step(12'hF02, 32'h1, 1'b1, 1'b0);
    chk("irq_set_wins", 32'(irq), 32'd1);
    step(12'hF02, 32'h1, 1'b1, 1'b0);
    chk("irq_cleared2", 32'(irq), 32'd0);
`else
    step(12'hF01, 32'd50, 1'b1, 1'b0);
    step(12'hF01, 32'd0, 1'b0, 1'b0);
    chk("tcmp_reads_0", q, 32'd0);
    for (int i = 0; i < 60; i++) idle(1'b0);
    chk("irq_never", 32'(irq), 32'd0);
`endif

    for (int i = 1; i <= 5; i++) step(12'hF03, 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    step(12'hF02, 32'd0, 1'b0, 1'b0);
    chk("status_ovf_full", {26'b0, q[6:1]}, 32'h25);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", out_data, 32'hA000_0000 + 32'(i));
      idle(1'b1);
    end
    chk("drained", 32'(out_valid), 32'd0);
    step(12'hF02, 32'h8, 1'b1, 1'b0);
    step(12'hF02, 32'd0, 1'b0, 1'b0);
    chk("status_empty", q, 32'h4);

    for (int i = 1; i <= 4; i++) step(12'hF03, 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    step(12'hF03, 32'hB000_0005, 1'b1, 1'b1);
    step(12'hF02, 32'd0, 1'b0, 1'b0);
    chk("full_push_pop", {26'b0, q[6:1]}, 32'h21);

    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 3))
        0, 1: step(12'hF03, $urandom, 1'b1, 1'($urandom_range(0, 1)));
        2: step(12'hF02, 32'($urandom_range(0, 1)) << 3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        default: idle(1'($urandom_range(0, 1)));
      endcase
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    for (int i = 1; i <= 3; i++) step(12'hF03, 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
    step(12'hF00, 32'd0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    address   = 12'h800;
    wren      = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_data", out_data, 32'd0);
    chk("midreset_q", q, 32'd0);
    chk("midreset_irq", 32'(irq), 32'd0);
    model_reset();
    @(negedge clock) reset = 1'b1;
    step(12'hF02, 32'd0, 1'b0, 1'b0);
    chk("status_after_reset", q, 32'h4);
    step(12'hF00, 32'd0, 1'b0, 1'b0);
    chk("cycle_after_reset", q, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
